// File: rtl/rv_pkg.sv
// Shared RV32 fetch-path types and constants.
package rv_pkg;
    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [0:0] {
        FETCH_BOOT = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_pkt_t;
endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Synchronous FIFO of {instr, pc} packets; flush beats push, push+pop on full is legal.
module fetch_queue
    import rv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  fetch_pkt_t       push_dat,
    input  logic             pop,
    input  logic             flush,
    output fetch_pkt_t       head_dat,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    fetch_pkt_t       mem_q [DEPTH];
    fetch_pkt_t       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// RISC-V fetch stage: owns the PC, issues credit-limited word fetches, queues
// returned words for decode and flushes/drops in-flight words on redirect.
module instruction_fetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          QUEUE_DEPTH = 2,
    parameter int          CNT_W       = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d;
    logic [31:0]      pc_fifo_q [QUEUE_DEPTH];
    logic [31:0]      pc_fifo_d [QUEUE_DEPTH];
    logic [PTR_W-1:0] pc_wr_q, pc_wr_d, pc_rd_q, pc_rd_d;

    fetch_pkt_t       q_head, q_push_dat;
    logic [CNT_W-1:0] q_count;
    logic             q_full, q_empty, q_push;
    logic             req_fire, dec_fire, resp_keep;

    // Credit: every accepted request must already own a queue slot.
    assign imem_req_valid = (state_q == FETCH_RUN) && !redirect_valid &&
                            ((int'(out_cnt_q) + int'(q_count)) < QUEUE_DEPTH);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign dec_valid  = !q_empty;
    assign dec_fire   = dec_valid && dec_ready;
    assign dec_instr  = q_empty ? '0 : q_head.instr;
    assign dec_pc     = q_empty ? '0 : q_head.pc;

    assign resp_keep  = imem_resp_valid && (drop_cnt_q == '0);
    assign q_push     = resp_keep && (!q_full || dec_fire);
    assign q_push_dat = '{instr: imem_resp_data, pc: pc_fifo_q[pc_rd_q]};

    fetch_queue #(.DEPTH(QUEUE_DEPTH), .CNT_W(CNT_W)) u_queue (
        .clock    (clock),
        .reset    (reset),
        .push     (q_push),
        .push_dat (q_push_dat),
        .pop      (dec_fire),
        .flush    (redirect_valid),
        .head_dat (q_head),
        .count    (q_count),
        .full     (q_full),
        .empty    (q_empty)
    );

    always_comb begin
        state_d    = FETCH_RUN;
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
        end
        out_cnt_d  = out_cnt_q + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);
        // Everything still in flight after this edge is stale, including a word landing now.
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            drop_cnt_d = out_cnt_d;
        end else if (imem_resp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
        pc_fifo_d = pc_fifo_q;
        pc_wr_d   = pc_wr_q;
        pc_rd_d   = pc_rd_q;
        if (req_fire) begin
            pc_fifo_d[pc_wr_q] = fetch_pc_q;
            pc_wr_d            = pc_wr_q + PTR_W'(1);
        end
        if (imem_resp_valid) begin
            pc_rd_d = pc_rd_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= FETCH_BOOT;
            fetch_pc_q <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            pc_wr_q    <= '0;
            pc_rd_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            pc_wr_q    <= pc_wr_d;
            pc_rd_q    <= pc_rd_d;
        end
    end

    always_ff @(posedge clock) begin
        pc_fifo_q <= pc_fifo_d;
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized scoreboard bench for instruction_fetch_unit with an in-bench memory model.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        dec_valid, dec_ready = 1'b0;
    logic [31:0] dec_instr, dec_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    instruction_fetch_unit #(.RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_instr       (dec_instr),
        .dec_pc          (dec_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t       pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] dec_log[$];
    int          cyc = 0, tests = 0, fails = 0;
    int          lat_lo = 1, lat_hi = 1, last_due = 0;
    int          rst_cyc = -1, first_acc = -1, first_dv = -1, acc_cnt = 0;
    logic [31:0] model_pc = RST_PC;
    bit          prev_hold = 0, prev_redir = 0, prev_rst = 0;
    logic [31:0] hold_pc, hold_instr;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F13;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor + reference model: accepted requests become expected decode words in
    // program order; a redirect discards every expected word not yet handed to decode.
    always @(negedge clock) begin
        if (prev_rst) begin
            check1("rst_req_valid", imem_req_valid, 1'b0);
            check1("rst_dec_valid", dec_valid, 1'b0);
            check("rst_dec_instr", dec_instr, 32'h0);
            check("rst_dec_pc", dec_pc, 32'h0);
            check("rst_req_addr", imem_req_addr, RST_PC);
        end
        if (reset) begin
            exp_q.delete();
            pend.delete();
            model_pc   = RST_PC;
            rst_cyc    = cyc;
            first_acc  = -1;
            first_dv   = -1;
            last_due   = 0;
            prev_hold  = 0;
            prev_redir = 0;
        end else begin
            if (prev_redir) check1("dv_after_redirect", dec_valid, 1'b0);
            if (prev_hold) begin
                check1("hold_valid", dec_valid, 1'b1);
                check("hold_pc", dec_pc, hold_pc);
                check("hold_instr", dec_instr, hold_instr);
            end
            if (redirect_valid) check1("no_req_in_redirect", imem_req_valid, 1'b0);
            if (dec_valid && first_dv < 0) first_dv = cyc;
            if (dec_valid && dec_ready) begin
                dec_log.push_back(dec_pc);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL dec_unexpected: got pc %h expected no word (cycle %0d)", dec_pc, cyc);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("dec_pc", dec_pc, e);
                    check("dec_instr", dec_instr, memword(e));
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                pend_t p;
                int    due;
                check("req_addr", imem_req_addr, model_pc);
                exp_q.push_back(model_pc);
                due = cyc + $urandom_range(lat_hi, lat_lo);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                p.addr = imem_req_addr;
                p.due  = due;
                pend.push_back(p);
                model_pc = model_pc + 32'd4;
                acc_cnt++;
                if (first_acc < 0) first_acc = cyc;
            end
            if (redirect_valid) begin
                exp_q.delete();
                model_pc = redirect_pc & 32'hFFFF_FFFC;
            end
            prev_hold  = dec_valid && !dec_ready && !redirect_valid;
            hold_pc    = dec_pc;
            hold_instr = dec_instr;
            prev_redir = redirect_valid;
        end
        prev_rst = reset;
    end

    task automatic step(input int rdy_pct, input int drdy_pct, input int redir_pct,
                        input bit rst, input bit use_fixed, input logic [31:0] fixed_pc);
        @(posedge clock);
        #1;
        reset           = rst;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = memword(pend[0].addr);
            void'(pend.pop_front());
        end
        imem_req_ready = int'($urandom_range(99)) < rdy_pct;
        dec_ready      = int'($urandom_range(99)) < drdy_pct;
        redirect_valid = int'($urandom_range(99)) < redir_pct;
        if (use_fixed) redirect_pc = fixed_pc;
        else if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
        else redirect_pc = $urandom();
    endtask

    task automatic run(input int n, input int rdy, input int drdy, input int redir, input int rst_per_mille);
        for (int i = 0; i < n; i++)
            step(rdy, drdy, redir, int'($urandom_range(999)) < rst_per_mille, 1'b0, 32'h0);
    endtask

    initial begin
        // Reset state and first-fetch latency with a one-cycle memory.
        lat_lo = 1; lat_hi = 1;
        step(100, 100, 0, 1'b1, 1'b0, 32'h0);
        step(100, 100, 0, 1'b1, 1'b0, 32'h0);
        run(20, 100, 100, 0, 0);
        check("boot_gap", 32'(first_acc - rst_cyc), 32'd2);
        check("first_dec_latency", 32'(first_dv - first_acc), 32'd2);

        // Decode stalled: only DEPTH words may be fetched, then fetch resumes after one pop.
        step(100, 0, 0, 1'b1, 1'b0, 32'h0);
        acc_cnt = 0;
        run(12, 100, 0, 0, 0);
        #1;
        check("stall_accepts", 32'(acc_cnt), 32'(DEPTH));
        check1("stall_req_valid", imem_req_valid, 1'b0);
        check1("stall_dec_valid", dec_valid, 1'b1);
        step(100, 100, 0, 1'b0, 1'b0, 32'h0);
        step(100, 0, 0, 1'b0, 1'b0, 32'h0);
        #1;
        check1("resume_req_valid", imem_req_valid, 1'b1);
        run(10, 100, 100, 0, 0);

        // Two requests in flight (latency 3), then redirect to 0x100.
        lat_lo = 3; lat_hi = 3;
        step(100, 0, 0, 1'b1, 1'b0, 32'h0);
        run(4, 100, 0, 0, 0);
        dec_log.delete();
        step(100, 0, 100, 1'b0, 1'b1, 32'h0000_0100);
        run(20, 100, 100, 0, 0);
        check("redir_first_pc", (dec_log.size() > 0) ? dec_log[0] : 32'hDEAD_BEEF, 32'h100);
        check("redir_second_pc", (dec_log.size() > 1) ? dec_log[1] : 32'hDEAD_BEEF, 32'h104);

        // Redirect landing with a response and a decode handshake in the same cycle.
        lat_lo = 1; lat_hi = 1;
        step(100, 100, 0, 1'b1, 1'b0, 32'h0);
        dec_log.delete();
        run(3, 100, 100, 0, 0);
        step(100, 100, 100, 1'b0, 1'b1, 32'h0000_0100);
        run(12, 100, 100, 0, 0);
        check("coincide_first_pc", (dec_log.size() > 0) ? dec_log[0] : 32'hDEAD_BEEF, 32'h0);
        check("coincide_next_pc", (dec_log.size() > 1) ? dec_log[1] : 32'hDEAD_BEEF, 32'h100);

        // Misaligned redirect during BOOT, then PC wrap past the top of memory.
        lat_lo = 1; lat_hi = 2;
        step(100, 100, 0, 1'b1, 1'b0, 32'h0);
        dec_log.delete();
        step(100, 100, 100, 1'b0, 1'b1, 32'hFFFF_FFFE);
        run(14, 100, 100, 0, 0);
        check("wrap_first_pc", (dec_log.size() > 0) ? dec_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check("wrap_second_pc", (dec_log.size() > 1) ? dec_log[1] : 32'hDEAD_BEEF, 32'h0);

        // Reset while the queue is full.
        run(10, 100, 0, 0, 0);
        step(100, 0, 0, 1'b1, 1'b0, 32'h0);
        run(6, 100, 0, 0, 0);
        check("reset_full_gap", 32'(first_acc - rst_cyc), 32'd2);

        // Randomized traffic under several memory/decode/redirect mixes.
        lat_lo = 1; lat_hi = 1; run(600, 100, 100, 5, 2);
        lat_lo = 1; lat_hi = 4; run(600, 70, 60, 8, 2);
        lat_lo = 2; lat_hi = 6; run(600, 50, 30, 15, 3);
        lat_lo = 1; lat_hi = 3; run(600, 90, 90, 30, 2);
        run(30, 0, 100, 0, 0);
        #1;
        check("drain_expected_empty", 32'(exp_q.size()), 32'd0);
        check1("drain_dec_valid", dec_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage of the RISC-V datapath, directly upstream of decode and the immediate generator.
- Owns the PC register and issues word fetches to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned instruction words in a small queue and presents {instruction, pc} to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute, flushes queued and in-flight words, then restarts fetch at the new PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset. Bits [1:0] must be 0.
- QUEUE_DEPTH, 2, instruction queue entries. Power of two, 2..8.
- CNT_W, $clog2(QUEUE_DEPTH)+1, width of the outstanding/drop counters.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high.
- imem_req_valid, output, 1, fetch request valid.
- imem_req_ready, input, 1, memory accepts request.
- imem_req_addr, output, 32, word address of fetch (byte address, [1:0]=0).
- imem_resp_valid, input, 1, response word valid. In order, latency ≥1 cycle, no backpressure.
- imem_resp_data, input, 32, fetched instruction word.
- dec_valid, output, 1, instruction available to decode.
- dec_ready, input, 1, decode consumes instruction.
- dec_instr, output, 32, instruction word (opcode at [6:0]).
- dec_pc, output, 32, PC of dec_instr.
- redirect_valid, input, 1, taken branch/jump from execute.
- redirect_pc, input, 32, new fetch target. Bits [1:0] ignored and treated as 00.

Behaviour:
- Reset (synchronous, active-high): fetch_pc=RESET_PC, queue empty, outstanding=0, drop=0, state=BOOT. Outputs imem_req_valid=0, dec_valid=0, dec_instr=0, dec_pc=0, imem_req_addr=RESET_PC.
- Reset asserted mid-operation discards everything. Responses for pre-reset requests arriving after reset are the memory's responsibility; the unit counts none.
- FSM:
  - BOOT: one cycle, no requests, then RUN.
  - RUN: normal fetch.
- Request issue (RUN only): imem_req_valid = (outstanding + queue_count < QUEUE_DEPTH) && !redirect_valid. imem_req_addr = fetch_pc.
- On imem_req_valid && imem_req_ready: outstanding+1, fetch_pc += 4. fetch_pc wraps 32'hFFFF_FFFC -> 0 silently.
- Response with drop==0: push {data, pc_of_request} into queue, outstanding-1. The request PC is carried in a parallel PC FIFO of depth QUEUE_DEPTH.
- Response with drop>0: discard, drop-1, outstanding-1.
- Queue never overflows: the credit rule guarantees space for every accepted request.
- dec_valid = queue non-empty. dec_instr/dec_pc = queue head, held stable while dec_valid && !dec_ready. Pop on dec_valid && dec_ready.
- Latency: request accepted at cycle N, response at N+L, dec_valid high at N+L+1 (registered queue). Zero-latency bypass is forbidden.
- Redirect, at clock edge with redirect_valid=1:
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - Queue flushed; dec_valid=0 next cycle.
  - drop <= outstanding_next, i.e. all requests in flight after this edge, including one whose response arrives this same cycle, which is itself dropped.
  - No request is issued in the redirect cycle.
  - A dec handshake in the same cycle completes normally: decode owns that word.
- Back-to-back redirects: latest target wins; drop recomputed each time.
- Redirect during BOOT: fetch_pc updated; BOOT still lasts its single cycle.
- Simultaneous push and pop on a full queue is legal; count is unchanged.

Decomposition:
- Shared package rv_pkg: XLEN=32, INSTR_BYTES=4, RESET_PC default, fetch state enum {FETCH_BOOT, FETCH_RUN}, and a struct fetch_pkt_t {instr[31:0], pc[31:0]}.
- One sub-module, fetch_queue: synchronous FIFO of fetch_pkt_t with push, pop, flush, count, full, empty. Flush has priority over push in the same cycle.

Test Plan:
- Reset, memory latency 1, dec_ready=1 -> addrs 0x0, 0x4, 0x8 issued on consecutive cycles; dec_pc 0x0 first seen 2 cycles after first accept.
- Hold dec_ready=0 -> at most QUEUE_DEPTH=2 requests accepted, then imem_req_valid=0. dec_instr/dec_pc stable; fetch resumes one cycle after dec_ready=1.
- With 2 in flight (latency 3), redirect_pc=0x100 -> both stale responses dropped. Next dec_pc=0x100, then 0x104; no stale word ever reaches decode.
- Redirect coincides with a response and a dec handshake -> handshaken word consumed once, response dropped, next dec_pc=0x100.
- redirect_pc=0xFFFF_FFFE -> fetch at 0xFFFF_FFFC, then wraps to 0x0000_0000.
- Assert reset mid-stream with queue full -> next cycle dec_valid=0, imem_req_valid=0. First request two cycles later at RESET_PC.
